// File: rtl/bram_arbiter.sv
// Single-port frame BRAM arbiter: VGA strict priority, fetch/core round-robin
// with bounded bursts, read-valid strobes aligned to the 1-cycle BRAM latency.
module bram_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req_i,
    input  logic [ADDR_W-1:0] vga_addr_i,
    output logic              vga_gnt_o,
    output logic              vga_rvalid_o,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_rvalid_o,
    input  logic              core_req_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_gnt_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              bram_en_o,
    output logic              bram_we_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_wdata_o,
    input  logic [DATA_W-1:0] bram_rdata_i,
    output logic [1:0]        owner_o
);

    localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VGA   = 2'd1,
        S_FETCH = 2'd2,
        S_CORE  = 2'd3
    } state_t;

    state_t           owner, owner_d;
    logic [CNT_W-1:0] beat_cnt, beat_d;
    logic             last_rr, last_rr_d;
    logic             vga_rv, fetch_rv;
    logic             own_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= S_IDLE;
            beat_cnt <= '0;
            last_rr  <= 1'b1;
            vga_rv   <= 1'b0;
            fetch_rv <= 1'b0;
        end else begin
            owner    <= owner_d;
            beat_cnt <= beat_d;
            last_rr  <= last_rr_d;
            vga_rv   <= vga_gnt_o;
            fetch_rv <= fetch_gnt_o;
        end
    end

    assign vga_gnt_o   = (owner == S_VGA) & vga_req_i;
    assign fetch_gnt_o = (owner == S_FETCH) & fetch_req_i;
    assign core_gnt_o  = (owner == S_CORE) & core_req_i;

    assign bram_en_o      = vga_gnt_o | fetch_gnt_o | core_gnt_o;
    assign bram_we_o      = core_gnt_o;
    assign bram_wdata_o   = (owner == S_CORE) ? core_wdata_i : '0;
    assign vga_rvalid_o   = vga_rv;
    assign fetch_rvalid_o = fetch_rv;
    assign rdata_o        = bram_rdata_i;
    assign owner_o        = owner;

    always_comb begin
        bram_addr_o = '0;
        unique case (1'b1)
            vga_gnt_o:   bram_addr_o = vga_addr_i;
            fetch_gnt_o: bram_addr_o = fetch_addr_i;
            core_gnt_o:  bram_addr_o = core_addr_i;
            default:     bram_addr_o = '0;
        endcase
    end

    always_comb begin
        owner_d   = owner;
        beat_d    = beat_cnt;
        last_rr_d = last_rr;
        own_req   = 1'b0;
        unique case (owner)
            S_IDLE: begin
                beat_d = '0;
                if (vga_req_i)
                    owner_d = S_VGA;
                else if (fetch_req_i && core_req_i)
                    owner_d = last_rr ? S_FETCH : S_CORE;
                else if (fetch_req_i)
                    owner_d = S_FETCH;
                else if (core_req_i)
                    owner_d = S_CORE;
            end
            S_VGA: begin
                if (!vga_req_i)
                    owner_d = S_IDLE;
            end
            S_FETCH, S_CORE: begin
                own_req = (owner == S_FETCH) ? fetch_req_i : core_req_i;
                if (own_req)
                    beat_d = beat_cnt + 1'b1;
                // VGA preempts straight after the current beat
                if (!own_req || vga_req_i || beat_cnt == LAST_BEAT) begin
                    owner_d   = (own_req && vga_req_i) ? S_VGA : S_IDLE;
                    beat_d    = '0;
                    last_rr_d = (owner == S_CORE);
                end
            end
            default: owner_d = S_IDLE;
        endcase
    end

endmodule
